// File: rtl/lcd_char_buffer.sv
// 32-cell character buffer between an SPI byte receiver and an LCD1602 driver.
// Optional control-code decoding (clear sweep, CR, LF, BS) is enabled by defining LCD_BUF_CTRL_EN.
module lcd_char_buffer #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic       lcd_clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_toggle,
  input  logic       lcd_we,
  output logic [4:0] char_count,
  output logic [7:0] data_display,
  output logic [4:0] wr_ptr,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  logic [7:0] r_cells [0:31];
  logic       r_sync1;
  logic       r_sync2;
  logic       r_hist;
  logic       w_evt;
  logic [4:0] r_char_count;
  logic [4:0] r_wr_ptr;
  logic       r_frame_done;
  logic       w_wr_en;
  logic [4:0] w_wr_addr;
  logic [7:0] w_wr_data;
  logic [4:0] w_wr_ptr_nxt;

  // rx_toggle crosses from the SPI domain; the history flop turns each level change into one event
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= rx_toggle;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_evt = r_sync2 ^ r_hist;

  // Readout index runs freely under the driver's strobe, independent of any clear sweep
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_char_count <= 5'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= lcd_we && (r_char_count == 5'd31);
      if (lcd_we) begin
        r_char_count <= r_char_count + 5'd1;
      end else begin
        r_char_count <= r_char_count;
      end
    end
  end

`ifdef LCD_BUF_CTRL_EN
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_clr_idx;
  logic [4:0] w_clr_idx_nxt;
  logic       r_pend_valid;
  logic       w_pend_valid_nxt;
  logic [7:0] r_pend_data;
  logic [7:0] w_pend_data_nxt;
  logic       r_overrun;
  logic       w_overrun_nxt;
  logic       w_go;
  logic [7:0] w_byte;

  // State, sweep index, one-entry pending slot and sticky overrun
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_clr_idx    <= 5'd0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= 8'h00;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_idx    <= w_clr_idx_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_data  <= w_pend_data_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  // A held byte is served before any new event; a new event colliding with it is lost
  always_comb begin
    w_state_nxt      = r_state;
    w_clr_idx_nxt    = r_clr_idx;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_data_nxt  = r_pend_data;
    w_overrun_nxt    = r_overrun;
    w_wr_en          = 1'b0;
    w_wr_addr        = r_wr_ptr;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_go             = 1'b0;
    w_byte           = r_pend_valid ? r_pend_data : rx_data;
    w_wr_data        = w_byte;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_valid) begin
          w_go             = 1'b1;
          w_pend_valid_nxt = 1'b0;
          w_overrun_nxt    = r_overrun | w_evt;
        end else begin
          w_go = w_evt;
        end
        if (w_go) begin
          case (w_byte)
            8'h0C: begin
              w_state_nxt   = ST_CLEAR;
              w_clr_idx_nxt = 5'd0;
            end
            8'h0D:   w_wr_ptr_nxt = {r_wr_ptr[4], 4'h0};
            8'h0A:   w_wr_ptr_nxt = {~r_wr_ptr[4], 4'h0};
            8'h08:   w_wr_ptr_nxt = r_wr_ptr - 5'd1;
            default: begin
              if (w_byte[7:5] != 3'b000) begin
                w_wr_en      = 1'b1;
                w_wr_ptr_nxt = r_wr_ptr + 5'd1;
              end else begin
                w_wr_en = 1'b0;
              end
            end
          endcase
        end else begin
          w_wr_en = 1'b0;
        end
      end
      ST_CLEAR: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_clr_idx;
        w_wr_data = FILL_CHAR;
        if (r_clr_idx == 5'd31) begin
          w_state_nxt  = ST_IDLE;
          w_wr_ptr_nxt = 5'd0;
        end else begin
          w_clr_idx_nxt = r_clr_idx + 5'd1;
        end
        if (w_evt && r_pend_valid) begin
          w_overrun_nxt = 1'b1;
        end else if (w_evt) begin
          w_pend_valid_nxt = 1'b1;
          w_pend_data_nxt  = rx_data;
        end else begin
          w_pend_valid_nxt = r_pend_valid;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy    = (r_state == ST_CLEAR);
  assign overrun = r_overrun;
`else
  // Every received byte is printable in this build
  always_comb begin
    w_wr_en      = w_evt;
    w_wr_addr    = r_wr_ptr;
    w_wr_data    = rx_data;
    w_wr_ptr_nxt = w_evt ? (r_wr_ptr + 5'd1) : r_wr_ptr;
  end

  assign busy    = 1'b0;
  assign overrun = 1'b0;
`endif

  // Cursor register
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 5'd0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
    end
  end

  // Cell array; single write port shared by byte writes and the clear sweep
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_cells[i] <= FILL_CHAR;
      end
    end else if (w_wr_en) begin
      r_cells[w_wr_addr] <= w_wr_data;
    end
  end

  assign char_count   = r_char_count;
  assign data_display = r_cells[r_char_count];
  assign wr_ptr       = r_wr_ptr;
  assign frame_done   = r_frame_done;

endmodule
